ace_xack_router: RTL and testbench
==================================

# ace_xack_router

Routes ACE read/write acknowledge signals (RACK, WACK) from the upstream master to the master port whose response they acknowledge. It sits beside the ACE demultiplexer: it observes completed R and B transactions at the demux slave port, together with their source port index. It then forwards each incoming RACK/WACK as a one-cycle pulse to the correct downstream port, in transaction-completion order. Two independent index FIFOs (read and write) hold the routing order; the block raises a stall request when a FIFO is full.

## Interface

- NoMstPorts, 2, number of downstream master ports (≥1)
- MaxTrans, 8, depth of each index FIFO = max unacknowledged transactions per direction (≥1, any value)
- SelectWidth, NoMstPorts>1 ? $clog2(NoMstPorts) : 1, derived, do not override
- select_t, logic [SelectWidth-1:0], derived port index type

- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- b_done_i  in  1  B handshake (b_valid & b_ready) at slave port this cycle
- b_sel_i  in  select_t  master port that produced that B
- r_done_i  in  1  R handshake with r.last = 1 at slave port this cycle
- r_sel_i  in  select_t  master port that produced that last R beat
- wack_i  in  1  WACK from upstream master (1 = one acknowledge)
- rack_i  in  1  RACK from upstream master
- b_stall_o  out  1  write FIFO full; the B mux must not complete a handshake
- r_stall_o  out  1  read FIFO full; the R mux must not complete a last-beat handshake
- mst_wack_o  out  NoMstPorts  per-port WACK pulse
- mst_rack_o  out  NoMstPorts  per-port RACK pulse
- err_o  out  1  sticky protocol error flag

## Operation

- The write path (b_done_i / wack_i / mst_wack_o / b_stall_o) and the read path (r_done_i / rack_i / mst_rack_o / r_stall_o) are identical and fully independent; the read path is described here.
- FIFO state: storage of MaxTrans × select_t, write pointer, read pointer and count.
  - Pointers wrap from MaxTrans-1 to 0.
  - Count width is $clog2(MaxTrans+1).
- Push: on r_done_i, store r_sel_i at the write pointer.
- Pop: on rack_i while the pre-cycle count > 0, read the head index, advance the read pointer, and assert mst_rack_o[head] on the next cycle.
- Pop eligibility always uses the count before this cycle's push. An acknowledge can never consume an entry pushed in the same cycle.
- Simultaneous push and pop: both take effect and the count is unchanged.
- Underflow: rack_i with count == 0 produces no output pulse, sets err_o, and leaves the count unchanged. A simultaneous push still stores its entry.
- Overflow: r_done_i with count == MaxTrans and no pop is dropped, sets err_o, and leaves FIFO contents unchanged. With a simultaneous pop, the push is accepted.
- r_stall_o = (count == MaxTrans), decoded from registered count only; it has no combinational path from inputs.
- err_o is sticky until rst_i and is the OR of both paths' underflow and overflow events.
- An out-of-range sel (≥ NoMstPorts) is stored as-is. Its later pop sets err_o and pulses no port.
- Reset mid-operation discards all stored indices. An acknowledge pending in the output register does not appear.

## Timing

- Reset values:
  - mst_rack_o = 0, mst_wack_o = 0
  - r_stall_o = 0, b_stall_o = 0
  - err_o = 0
  - pointers and counts = 0
- Latency: rack_i/wack_i in cycle N → one-hot pulse on the routed port in cycle N+1, lasting exactly one cycle. At most one bit per vector is set.
- Back-to-back acknowledges in consecutive cycles produce consecutive pulses, which may target the same or different ports. Throughput is one acknowledge per direction per cycle.
- Push in cycle N is poppable by an acknowledge from cycle N+1 onward.
- Stall timing: a push that fills the FIFO in cycle N raises the stall output in cycle N+1. A pop in cycle N that leaves the FIFO non-full drops the stall in cycle N+1.
- err_o rises in the cycle after the offending event.

## Test plan

- Order routing: NoMstPorts=4; r_done with sel 2, 0, 3 in cycles 1–3; rack in cycles 5, 6, 7 → mst_rack_o = 0100, 0001, 1000 in cycles 6, 7, 8; err_o stays 0.
- Same-cycle push/pop: count=1 (head sel 1), r_done sel 0 together with rack in cycle N → mst_rack_o = 0010 in N+1, count stays 1, next rack → 0001.
- Full/wrap: MaxTrans=3; 3 b_done pushes → b_stall_o = 1 the next cycle. A 4th push in the same cycle as a wack is accepted. Run 7 push/pop rounds → pointer wrap, all pulses in order.
- Underflow and overflow: wack_i on empty → no pulse, err_o = 1 next cycle. After rst_i, a push at full without a pop → dropped, err_o = 1, contents unchanged.
- Independence and reset: interleave the read and write paths with opposite sels → no cross-routing. Assert rst_i in the same cycle as a rack → no pulse the next cycle; count 0 and outputs 0 the cycle after reset.

Source files
------------

// File: rtl/ace_xack_router_if.sv
// ace_xack_router_if
// Groups the acknowledge-routing signals between the ACE demux side and
// ace_xack_router.
//   slave  modport : router view (completions/acks in, stalls/pulses/err out)
//   master modport : driver view (demux + upstream master side)
// Signals:
//   b_done_i/b_sel_i, r_done_i/r_sel_i : completed B / last-R with source port
//   wack_i, rack_i                     : acknowledges from the upstream master
//   b_stall_o, r_stall_o               : index FIFO full
//   mst_wack_o, mst_rack_o             : one-hot per-port acknowledge pulses
//   err_o                              : sticky protocol error
interface ace_xack_router_if #(
  parameter int unsigned NoMstPorts = 2
);
  localparam int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  logic                   b_done_i;
  logic [SelectWidth-1:0] b_sel_i;
  logic                   r_done_i;
  logic [SelectWidth-1:0] r_sel_i;
  logic                   wack_i;
  logic                   rack_i;
  logic                   b_stall_o;
  logic                   r_stall_o;
  logic [NoMstPorts-1:0]  mst_wack_o;
  logic [NoMstPorts-1:0]  mst_rack_o;
  logic                   err_o;

  modport slave (
    input  b_done_i, b_sel_i, r_done_i, r_sel_i, wack_i, rack_i,
    output b_stall_o, r_stall_o, mst_wack_o, mst_rack_o, err_o
  );

  modport master (
    output b_done_i, b_sel_i, r_done_i, r_sel_i, wack_i, rack_i,
    input  b_stall_o, r_stall_o, mst_wack_o, mst_rack_o, err_o
  );
endinterface

// File: rtl/ace_xack_router.sv
// ace_xack_router
// Routes RACK/WACK from the upstream master back to the downstream master
// port whose R/B response is being acknowledged, in completion order.
// Each direction keeps its own FIFO of source-port indices.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : ace_xack_router_if.slave (completions, acks, stalls, pulses, err)

// One acknowledge path: index FIFO plus registered one-hot output pulse.
module ace_xack_path #(
  parameter int unsigned NoMstPorts  = 2,
  parameter int unsigned MaxTrans    = 8,
  parameter int unsigned SelectWidth = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   done_i,
  input  logic [SelectWidth-1:0] sel_i,
  input  logic                   ack_i,
  output logic                   stall_o,
  output logic [NoMstPorts-1:0]  pulse_o,
  output logic                   err_o
);
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  logic [SelectWidth-1:0] mem_q [MaxTrans];
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [CntW-1:0]        cnt_q;
  logic [NoMstPorts-1:0]  pulse_q, head_oh;
  logic [SelectWidth-1:0] head;
  logic                   full, pop, push, underflow, overflow, bad_sel;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Eligibility uses the registered count, so an ack never sees a same-cycle push.
  assign full      = (cnt_q == CntW'(MaxTrans));
  assign pop       = ack_i && (cnt_q != '0);
  assign underflow = ack_i && (cnt_q == '0);
  assign push      = done_i && (!full || pop);
  assign overflow  = done_i && full && !pop;
  assign head      = mem_q[rptr_q];

  // Decoding by equality lets an out-of-range index fall out as all-zero.
  always_comb begin
    head_oh = '0;
    for (int i = 0; i < int'(NoMstPorts); i++) head_oh[i] = (head == SelectWidth'(i));
  end

  assign bad_sel = pop && (head_oh == '0);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= sel_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      pulse_q <= pop ? head_oh : '0;
    end
  end

  assign stall_o = full;
  assign pulse_o = pulse_q;
  assign err_o   = underflow || overflow || bad_sel;
endmodule

module ace_xack_router #(
  parameter int unsigned NoMstPorts = 2,
  parameter int unsigned MaxTrans   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ace_xack_router_if.slave bus
);
  localparam int unsigned SelectWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  logic r_err, b_err, err_q;

  ace_xack_path #(
    .NoMstPorts (NoMstPorts),
    .MaxTrans   (MaxTrans),
    .SelectWidth(SelectWidth)
  ) u_rd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .done_i (bus.r_done_i),
    .sel_i  (bus.r_sel_i),
    .ack_i  (bus.rack_i),
    .stall_o(bus.r_stall_o),
    .pulse_o(bus.mst_rack_o),
    .err_o  (r_err)
  );

  ace_xack_path #(
    .NoMstPorts (NoMstPorts),
    .MaxTrans   (MaxTrans),
    .SelectWidth(SelectWidth)
  ) u_wr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .done_i (bus.b_done_i),
    .sel_i  (bus.b_sel_i),
    .ack_i  (bus.wack_i),
    .stall_o(bus.b_stall_o),
    .pulse_o(bus.mst_wack_o),
    .err_o  (b_err)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i)               err_q <= 1'b0;
    else if (r_err || b_err) err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
endmodule

// File: tb/tb_ace_xack_router.sv
module tb_ace_xack_router;
  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;

  ace_xack_router_if #(.NoMstPorts(4)) bus ();

  ace_xack_router #(.NoMstPorts(4), .MaxTrans(3)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Inputs applied before step() are captured at the next rising edge;
  // outputs are then read 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.r_done_i = 1'b0; bus.r_sel_i = '0; bus.rack_i = 1'b0;
    bus.b_done_i = 1'b0; bus.b_sel_i = '0; bus.wack_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL reset_rack got %b exp 0000", bus.mst_rack_o); end
    checks++; if (bus.mst_wack_o !== 4'b0000) begin errors++; $display("FAIL reset_wack got %b exp 0000", bus.mst_wack_o); end
    checks++; if (bus.r_stall_o !== 1'b0) begin errors++; $display("FAIL reset_rstall got %b exp 0", bus.r_stall_o); end
    checks++; if (bus.b_stall_o !== 1'b0) begin errors++; $display("FAIL reset_bstall got %b exp 0", bus.b_stall_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_order();
    do_reset();
    bus.r_done_i = 1'b1; bus.r_sel_i = 2'd2; step();
    bus.r_sel_i = 2'd0; step();
    bus.r_sel_i = 2'd3; step();
    checks++; if (bus.r_stall_o !== 1'b1) begin errors++; $display("FAIL order_stall_full got %b exp 1", bus.r_stall_o); end
    bus.r_done_i = 1'b0; step();
    bus.rack_i = 1'b1; step();
    checks++; if (bus.mst_rack_o !== 4'b0100) begin errors++; $display("FAIL order_p0 got %b exp 0100", bus.mst_rack_o); end
    checks++; if (bus.r_stall_o !== 1'b0) begin errors++; $display("FAIL order_stall_drop got %b exp 0", bus.r_stall_o); end
    step();
    checks++; if (bus.mst_rack_o !== 4'b0001) begin errors++; $display("FAIL order_p1 got %b exp 0001", bus.mst_rack_o); end
    step();
    checks++; if (bus.mst_rack_o !== 4'b1000) begin errors++; $display("FAIL order_p2 got %b exp 1000", bus.mst_rack_o); end
    bus.rack_i = 1'b0; step();
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL order_idle got %b exp 0000", bus.mst_rack_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL order_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.r_done_i = 1'b1; bus.r_sel_i = 2'd1; step();
    bus.r_sel_i = 2'd0; bus.rack_i = 1'b1; step();
    checks++; if (bus.mst_rack_o !== 4'b0010) begin errors++; $display("FAIL same_p0 got %b exp 0010", bus.mst_rack_o); end
    bus.r_done_i = 1'b0; step();
    checks++; if (bus.mst_rack_o !== 4'b0001) begin errors++; $display("FAIL same_p1 got %b exp 0001", bus.mst_rack_o); end
    bus.rack_i = 1'b0; step();
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL same_idle got %b exp 0000", bus.mst_rack_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL same_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_full_wrap();
    int q[$];
    logic [3:0] exp_oh;
    logic [1:0] s;
    do_reset();
    bus.b_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = 2'(i); bus.b_sel_i = s; q.push_back(i); step();
    end
    checks++; if (bus.b_stall_o !== 1'b1) begin errors++; $display("FAIL wrap_stall_full got %b exp 1", bus.b_stall_o); end
    // Push at full together with a pop is accepted, then 7 more balanced rounds.
    for (int r = 0; r < 8; r++) begin
      s = (r == 0) ? 2'd3 : 2'(r);
      bus.b_sel_i = s; bus.wack_i = 1'b1;
      exp_oh = 4'b0001 << q[0];
      void'(q.pop_front()); q.push_back(int'(s));
      step();
      checks++; if (bus.mst_wack_o !== exp_oh) begin errors++; $display("FAIL wrap_round%0d got %b exp %b", r, bus.mst_wack_o, exp_oh); end
    end
    checks++; if (bus.b_stall_o !== 1'b1) begin errors++; $display("FAIL wrap_stall_hold got %b exp 1", bus.b_stall_o); end
    bus.b_done_i = 1'b0;
    for (int d = 0; d < 3; d++) begin
      exp_oh = 4'b0001 << q[0];
      void'(q.pop_front());
      step();
      checks++; if (bus.mst_wack_o !== exp_oh) begin errors++; $display("FAIL wrap_drain%0d got %b exp %b", d, bus.mst_wack_o, exp_oh); end
      if (d == 0) begin
        checks++; if (bus.b_stall_o !== 1'b0) begin errors++; $display("FAIL wrap_stall_drop got %b exp 0", bus.b_stall_o); end
      end
    end
    bus.wack_i = 1'b0; step();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", bus.err_o); end
  endtask

  task automatic test_underflow_overflow();
    do_reset();
    bus.wack_i = 1'b1; step();
    checks++; if (bus.mst_wack_o !== 4'b0000) begin errors++; $display("FAIL under_pulse got %b exp 0000", bus.mst_wack_o); end
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL under_err got %b exp 1", bus.err_o); end
    do_reset();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", bus.err_o); end
    bus.r_done_i = 1'b1;
    bus.r_sel_i = 2'd1; step();
    bus.r_sel_i = 2'd2; step();
    bus.r_sel_i = 2'd3; step();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL over_pre_err got %b exp 0", bus.err_o); end
    bus.r_sel_i = 2'd0; step();
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL over_err got %b exp 1", bus.err_o); end
    checks++; if (bus.r_stall_o !== 1'b1) begin errors++; $display("FAIL over_stall got %b exp 1", bus.r_stall_o); end
    bus.r_done_i = 1'b0; bus.rack_i = 1'b1; step();
    checks++; if (bus.mst_rack_o !== 4'b0010) begin errors++; $display("FAIL over_p0 got %b exp 0010", bus.mst_rack_o); end
    step();
    checks++; if (bus.mst_rack_o !== 4'b0100) begin errors++; $display("FAIL over_p1 got %b exp 0100", bus.mst_rack_o); end
    step();
    checks++; if (bus.mst_rack_o !== 4'b1000) begin errors++; $display("FAIL over_p2 got %b exp 1000", bus.mst_rack_o); end
    step();
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL over_dropped got %b exp 0000", bus.mst_rack_o); end
    bus.rack_i = 1'b0; step();
  endtask

  task automatic test_indep_reset();
    do_reset();
    bus.r_done_i = 1'b1; bus.r_sel_i = 2'd0; bus.b_done_i = 1'b1; bus.b_sel_i = 2'd3; step();
    bus.r_sel_i = 2'd1; bus.b_sel_i = 2'd2; step();
    bus.r_done_i = 1'b0; bus.b_done_i = 1'b0; bus.rack_i = 1'b1; bus.wack_i = 1'b1; step();
    checks++; if (bus.mst_rack_o !== 4'b0001) begin errors++; $display("FAIL indep_r0 got %b exp 0001", bus.mst_rack_o); end
    checks++; if (bus.mst_wack_o !== 4'b1000) begin errors++; $display("FAIL indep_w0 got %b exp 1000", bus.mst_wack_o); end
    bus.wack_i = 1'b0; step();
    checks++; if (bus.mst_rack_o !== 4'b0010) begin errors++; $display("FAIL indep_r1 got %b exp 0010", bus.mst_rack_o); end
    checks++; if (bus.mst_wack_o !== 4'b0000) begin errors++; $display("FAIL indep_w_idle got %b exp 0000", bus.mst_wack_o); end
    bus.rack_i = 1'b0; bus.wack_i = 1'b1; step();
    checks++; if (bus.mst_wack_o !== 4'b0100) begin errors++; $display("FAIL indep_w1 got %b exp 0100", bus.mst_wack_o); end
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL indep_r_idle got %b exp 0000", bus.mst_rack_o); end
    bus.wack_i = 1'b0;
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL indep_err got %b exp 0", bus.err_o); end
    // Reset arriving with an ack discards both the entry and the pending pulse.
    bus.r_done_i = 1'b1; bus.r_sel_i = 2'd2; step();
    bus.r_done_i = 1'b0; bus.rack_i = 1'b1; rst_i = 1'b1; step();
    rst_i = 1'b0; bus.rack_i = 1'b0;
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL rst_pulse got %b exp 0000", bus.mst_rack_o); end
    checks++; if (bus.r_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.r_stall_o); end
    bus.rack_i = 1'b1; step();
    checks++; if (bus.mst_rack_o !== 4'b0000) begin errors++; $display("FAIL rst_empty_pulse got %b exp 0000", bus.mst_rack_o); end
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL rst_empty_err got %b exp 1", bus.err_o); end
    bus.rack_i = 1'b0; step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    idle();
    test_reset();
    test_order();
    test_same_cycle();
    test_full_wrap();
    test_underflow_overflow();
    test_indep_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
